// File: rtl/qsn_syndrome_check.sv
// ---------------------------------------------------------------------------
// qsn_syndrome_check
//
// Purpose:
//   Sits directly behind the quasi-cyclic shift network of the LDPC decoder.
//   Each beat carries one cyclically shifted Z-bit hard-decision block. The
//   blocks of one base-matrix row are XOR-accumulated into that row's Z
//   parity checks (the row syndrome). After the last row it reports whether
//   every check is satisfied. The decoder uses this as its early-termination
//   test.
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   rst           synchronous active-high reset
//   start         one-cycle pulse, begins a new codeword check (top priority)
//   in_valid      in_data/in_last carry a valid block this cycle
//   in_data       shifted block from the QSN output [LiftingFactor-1:0]
//   in_last       final block of the current row (qualified by in_valid)
//   busy          high while accumulating
//   done          one-cycle pulse, the check is complete
//   pass          all row syndromes zero, held until the next start
//   fail_row      first row with a nonzero syndrome (meaningful when pass=0)
//   row_syndrome  syndrome of the most recently completed row
//   drop          sticky, a beat arrived while not accumulating
//   unsat_count   saturating count of unsatisfied checks (SYND_WEIGHT_EN only)
//
// Configuration macro:
//   SYND_WEIGHT_EN  adds the unsat_count output and its counter.
// ---------------------------------------------------------------------------
module qsn_syndrome_check #(
  parameter int LiftingFactor = 4,
  parameter int NumRows       = 3,
  parameter int RowCountWidth = 2,
  parameter int WeightWidth   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [LiftingFactor-1:0] in_data,
  input  logic                     in_last,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [RowCountWidth-1:0] fail_row,
  output logic [LiftingFactor-1:0] row_syndrome,
  output logic                     drop
`ifdef SYND_WEIGHT_EN
  ,
  output logic [WeightWidth-1:0]   unsat_count
`endif
);

  // Reject configurations whose row counter cannot reach the last row.
  if ((1 << RowCountWidth) < NumRows || WeightWidth < 1) begin : g_bad_cfg
    $error("qsn_syndrome_check: RowCountWidth too small for NumRows or WeightWidth < 1");
  end

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [RowCountWidth-1:0] LastRow = RowCountWidth'(NumRows - 1);

  logic [1:0]               state_q,     state_d;
  logic [LiftingFactor-1:0] acc_q,       acc_d;
  logic [RowCountWidth-1:0] row_cnt_q,   row_cnt_d;
  logic                     pass_q,      pass_d;
  logic                     fail_seen_q, fail_seen_d;
  logic [RowCountWidth-1:0] fail_row_q,  fail_row_d;
  logic [LiftingFactor-1:0] row_syn_q,   row_syn_d;
  logic                     drop_q,      drop_d;

  // Running XOR including this beat; on a last beat it is the row syndrome.
  logic [LiftingFactor-1:0] acc_x;
  assign acc_x = acc_q ^ in_data;

`ifdef SYND_WEIGHT_EN
  localparam int SumW = WeightWidth + LiftingFactor;

  logic [WeightWidth-1:0] unsat_q, unsat_d;
  logic [SumW-1:0]        unsat_sum;

  function automatic logic [SumW-1:0] popcount(input logic [LiftingFactor-1:0] v);
    logic [SumW-1:0] n;
    n = '0;
    for (int i = 0; i < LiftingFactor; i++) begin
      n = n + SumW'(v[i]);
    end
    return n;
  endfunction

  // Wide enough that the add never wraps before the saturation compare.
  assign unsat_sum = SumW'(unsat_q) + popcount(acc_x);
`endif

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path through
    // the branches below leaves it unassigned, which would infer a latch.
    state_d     = state_q;
    acc_d       = acc_q;
    row_cnt_d   = row_cnt_q;
    pass_d      = pass_q;
    fail_seen_d = fail_seen_q;
    fail_row_d  = fail_row_q;
    row_syn_d   = row_syn_q;
    drop_d      = drop_q;
`ifdef SYND_WEIGHT_EN
    unsat_d     = unsat_q;
`endif

    if (start) begin
      // A beat arriving alongside start is discarded, not counted as a drop.
      state_d     = ACCUM;
      acc_d       = '0;
      row_cnt_d   = '0;
      pass_d      = 1'b1;
      fail_seen_d = 1'b0;
      fail_row_d  = '0;
      drop_d      = 1'b0;
`ifdef SYND_WEIGHT_EN
      unsat_d     = '0;
`endif
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_valid) begin
            if (!in_last) begin
              acc_d = acc_x;
            end else begin
              row_syn_d = acc_x;
              acc_d     = '0;
              if (acc_x != '0) begin
                pass_d = 1'b0;
                if (!fail_seen_q) begin
                  fail_row_d  = row_cnt_q;
                  fail_seen_d = 1'b1;
                end
              end
`ifdef SYND_WEIGHT_EN
              if (unsat_sum > SumW'({WeightWidth{1'b1}})) begin
                unsat_d = '1;
              end else begin
                unsat_d = unsat_sum[WeightWidth-1:0];
              end
`endif
              if (row_cnt_q == LastRow) begin
                state_d   = DONE;
                row_cnt_d = '0;
              end else begin
                row_cnt_d = row_cnt_q + 1'b1;
              end
            end
          end
        end
        DONE: begin
          state_d = IDLE;
          if (in_valid) drop_d = 1'b1;
        end
        default: begin
          // IDLE, and recovery from any unused encoding.
          state_d = IDLE;
          if (in_valid) drop_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      row_cnt_q   <= '0;
      pass_q      <= 1'b0;
      fail_seen_q <= 1'b0;
      fail_row_q  <= '0;
      row_syn_q   <= '0;
      drop_q      <= 1'b0;
`ifdef SYND_WEIGHT_EN
      unsat_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      row_cnt_q   <= row_cnt_d;
      pass_q      <= pass_d;
      fail_seen_q <= fail_seen_d;
      fail_row_q  <= fail_row_d;
      row_syn_q   <= row_syn_d;
      drop_q      <= drop_d;
`ifdef SYND_WEIGHT_EN
      unsat_q     <= unsat_d;
`endif
    end
  end

  assign busy         = (state_q == ACCUM);
  assign done         = (state_q == DONE);
  assign pass         = pass_q;
  assign fail_row     = fail_row_q;
  assign row_syndrome = row_syn_q;
  assign drop         = drop_q;
`ifdef SYND_WEIGHT_EN
  assign unsat_count  = unsat_q;
`endif

endmodule

// File: tb/tb_qsn_syndrome_check.sv
// ---------------------------------------------------------------------------
// tb_qsn_syndrome_check
//
// Self-checking bench for qsn_syndrome_check (LiftingFactor=4, NumRows=3).
// A codeword is held as a flat list of blocks plus per-row lengths; the
// expected outcome is derived from those lists directly: each row syndrome
// is the XOR of its blocks, pass means all are zero, fail_row is the first
// nonzero row, unsat_count is the saturated sum of syndrome popcounts.
// ---------------------------------------------------------------------------
module tb_qsn_syndrome_check;

  localparam int LF = 4;
  localparam int NR = 3;
  localparam int RW = 2;
  localparam int WW = 4;

  logic          clk;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic [LF-1:0] in_data;
  logic          in_last;
  logic          busy;
  logic          done;
  logic          pass;
  logic [RW-1:0] fail_row;
  logic [LF-1:0] row_syndrome;
  logic          drop;
`ifdef SYND_WEIGHT_EN
  logic [WW-1:0] unsat_count;
`endif

  qsn_syndrome_check #(
    .LiftingFactor(LF),
    .NumRows      (NR),
    .RowCountWidth(RW),
    .WeightWidth  (WW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .fail_row    (fail_row),
    .row_syndrome(row_syndrome),
    .drop        (drop)
`ifdef SYND_WEIGHT_EN
    ,
    .unsat_count (unsat_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Current codeword: blocks in send order, and the number of blocks per row.
  logic [LF-1:0] cw_blk[$];
  int            cw_len[NR];

  // Expected outcome of the current codeword.
  bit            exp_pass;
  int            exp_fail_row;
  logic [LF-1:0] exp_last_syn;
  int            exp_unsat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic compute_model();
    int            idx;
    logic [LF-1:0] s;
    bit            found;
    idx          = 0;
    found        = 0;
    exp_pass     = 1;
    exp_fail_row = 0;
    exp_unsat    = 0;
    exp_last_syn = '0;
    for (int r = 0; r < NR; r++) begin
      s = '0;
      for (int b = 0; b < cw_len[r]; b++) begin
        s = s ^ cw_blk[idx];
        idx++;
      end
      if (s != '0) begin
        exp_pass = 0;
        if (!found) begin
          exp_fail_row = r;
          found        = 1;
        end
      end
      exp_unsat = exp_unsat + $countones(s);
      if (exp_unsat > (1 << WW) - 1) exp_unsat = (1 << WW) - 1;
      exp_last_syn = s;
    end
  endtask

  task automatic do_start();
    start    = 1'b1;
    in_valid = 1'b0;
    tick();
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_pass", pass, 1);
    check("start_drop", drop, 0);
    check("start_done", done, 0);
  endtask

  // Sends every block of the current codeword; bubbles of bub_min..bub_max
  // idle cycles precede each beat when bub_max > 0.
  task automatic send_beats(input int bub_min, input int bub_max);
    int            idx;
    int            nb;
    logic [LF-1:0] rs;
    idx = 0;
    for (int r = 0; r < NR; r++) begin
      rs = '0;
      for (int b = 0; b < cw_len[r]; b++) begin
        nb = (bub_max > 0) ? int'($urandom_range(bub_max, bub_min)) : 0;
        for (int k = 0; k < nb; k++) begin
          in_valid = 1'b0;
          in_data  = LF'($urandom);
          tick();
          check("bubble_busy", busy, 1);
        end
        in_valid = 1'b1;
        in_data  = cw_blk[idx];
        in_last  = (b == cw_len[r] - 1);
        rs       = rs ^ cw_blk[idx];
        idx++;
        tick();
        if (b == cw_len[r] - 1) check("row_syndrome", row_syndrome, rs);
        if (!(r == NR - 1 && b == cw_len[r] - 1)) begin
          check("mid_busy", busy, 1);
          check("mid_done", done, 0);
        end
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called in the DONE cycle. dv drives a stray beat during DONE.
  task automatic check_result(input bit dv);
    compute_model();
    check("done_pulse", done, 1);
    check("done_busy", busy, 0);
    check("pass", pass, exp_pass);
    check("fail_row", fail_row, exp_fail_row);
    check("final_syn", row_syndrome, exp_last_syn);
`ifdef SYND_WEIGHT_EN
    check("unsat_count", unsat_count, exp_unsat);
`endif
    in_valid = dv;
    in_data  = LF'($urandom);
    in_last  = 1'($urandom);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("post_done", done, 0);
    check("post_busy", busy, 0);
    check("post_drop", drop, dv);
    check("hold_pass", pass, exp_pass);
    check("hold_syn", row_syndrome, exp_last_syn);
  endtask

  task automatic load_test1();
    cw_blk = '{4'b1010, 4'b1010, 4'b0001, 4'b0010, 4'b0011, 4'b0110, 4'b0110};
    cw_len = '{2, 3, 2};
  endtask

  task automatic load_random();
    int            len;
    logic [LF-1:0] x;
    logic [LF-1:0] v;
    cw_blk = {};
    for (int r = 0; r < NR; r++) begin
      len       = int'($urandom_range(4, 1));
      cw_len[r] = len;
      x         = '0;
      for (int b = 0; b < len; b++) begin
        v = LF'($urandom);
        // Half the rows are forced to a zero syndrome so passes also occur.
        if (b == len - 1 && $urandom_range(1, 0) == 1) v = x;
        x = x ^ v;
        cw_blk.push_back(v);
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_fail_row", fail_row, 0);
    check("rst_syn", row_syndrome, 0);
    check("rst_drop", drop, 0);
    rst = 1'b0;
    tick();

    // 1: passing codeword.
    load_test1();
    do_start();
    send_beats(0, 0);
    check_result(0);

    // 2: row1 ends with 0111 -> syndrome 0100, first failure in row 1.
    load_test1();
    cw_blk[4] = 4'b0111;
    do_start();
    send_beats(0, 0);
    check_result(0);

    // 3: passing codeword with 1..3 cycle bubbles.
    load_test1();
    do_start();
    send_beats(1, 3);
    check_result(0);

    // 6: beat while idle sets drop, nothing else changes; start clears it.
    in_valid = 1'b1;
    in_data  = 4'b1111;
    in_last  = 1'b1;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("idle_drop", drop, 1);
    check("idle_busy", busy, 0);
    check("idle_pass", pass, 1);
    check("idle_done", done, 0);

    // 4: restart with a concurrent beat discards both the partial row and it.
    load_test1();
    do_start();
    in_valid = 1'b1;
    in_data  = 4'b1111;
    in_last  = 1'b0;
    tick();
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'b1111;
    in_last  = 1'b0;
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    check("restart_busy", busy, 1);
    check("restart_drop", drop, 0);
    send_beats(0, 0);
    check_result(0);

    // 5: reset in the middle of row 1.
    cw_blk = '{4'b1111, 4'b0101, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    cw_len = '{1, 3, 2};
    do_start();
    in_valid = 1'b1;
    in_data  = 4'b1111;
    in_last  = 1'b1;
    tick();
    check("r0_syn", row_syndrome, 4'b1111);
    in_data = 4'b0101;
    in_last = 1'b0;
    tick();
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_pass", pass, 0);
    check("mrst_fail_row", fail_row, 0);
    check("mrst_syn", row_syndrome, 0);
    check("mrst_drop", drop, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("mrst_no_done", done, 0);
      check("mrst_idle", busy, 0);
    end

    // Randomized codewords: random row lengths, bubbles and stray DONE beats.
    for (int n = 0; n < 60; n++) begin
      load_random();
      do_start();
      send_beats(0, int'($urandom_range(2, 0)));
      check_result(1'($urandom));
      for (int k = 0; k < int'($urandom_range(2, 0)); k++) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
